// File: rtl/pad_pkg.sv
// Shared types and constants for the serial game-pad reader.
package pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } pad_state_t;

  localparam int PAD_BITS   = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/pad_reader_if.sv
// Bundle between one pad connector, its reader and the player's attack FSM.
interface pad_reader_if;
  import pad_pkg::*;

  logic                frame_tick;
  logic                pad_data;
  logic                pad_latch;
  logic                pad_clk;
  logic [PAD_BITS-1:0] buttons;
  logic                btn_atk;
  logic                btn_up;
  logic                btn_down;
  logic                btn_left;
  logic                btn_right;
  logic                buttons_valid;
  logic                busy;

  modport master (
    input  frame_tick, pad_data,
    output pad_latch, pad_clk, buttons, btn_atk, btn_up, btn_down,
           btn_left, btn_right, buttons_valid, busy
  );

  modport slave (
    output frame_tick, pad_data,
    input  pad_latch, pad_clk, buttons, btn_atk, btn_up, btn_down,
           btn_left, btn_right, buttons_valid, busy
  );

endinterface

// File: rtl/pad_reader_sync2.sv
// Two-flop synchronizer with a configurable reset level (pad lines idle high).
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pad_reader.sv
// Once-per-frame NES pad poller; define PAD_ATK_EDGE_EN to make btn_atk a
// single-poll press edge of A instead of the A level.
module pad_reader
  import pad_pkg::*;
#(
  parameter int CLK_DIV = 300
) (
  input  logic          clk,
  input  logic          reset,
  pad_reader_if.master  bus
);

  localparam logic [15:0] PH_LOAD  = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_IDX = 3'(PAD_BITS - 1);

  pad_state_t          r_state;
  logic [15:0]         r_phase;
  logic [2:0]          r_idx;
  logic                r_latch_second;
  logic [PAD_BITS-1:0] r_shift;
  logic [PAD_BITS-1:0] r_buttons;
  logic                r_pad_latch;
  logic                r_pad_clk;
  logic                r_valid;
  logic                r_busy;
  logic                r_btn_atk;
`ifdef PAD_ATK_EDGE_EN
  logic                r_prev_a;
`endif
  logic                w_pad_data;

  sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.pad_data),
    .o_q   (w_pad_data)
  );

  // Poll sequencer; the latch pulse is two CLK_DIV passes so the counter stays 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_phase        <= 16'd0;
      r_idx          <= 3'd0;
      r_latch_second <= 1'b0;
      r_shift        <= '0;
      r_buttons      <= '0;
      r_pad_latch    <= 1'b0;
      r_pad_clk      <= 1'b0;
      r_valid        <= 1'b0;
      r_busy         <= 1'b0;
      r_btn_atk      <= 1'b0;
`ifdef PAD_ATK_EDGE_EN
      r_prev_a       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.frame_tick) begin
            r_state        <= ST_LATCH;
            r_idx          <= 3'd0;
            r_latch_second <= 1'b0;
            r_phase        <= PH_LOAD;
            r_pad_latch    <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (r_phase != 16'd0) begin
            r_phase <= r_phase - 16'd1;
          end else if (!r_latch_second) begin
            r_latch_second <= 1'b1;
            r_phase        <= PH_LOAD;
          end else begin
            r_pad_latch <= 1'b0;
            r_phase     <= PH_LOAD;
            r_state     <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (r_phase != 16'd0) begin
            r_phase <= r_phase - 16'd1;
          end else begin
            r_shift[r_idx] <= ~w_pad_data;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
            end else begin
              r_state   <= ST_HIGH;
              r_pad_clk <= 1'b1;
              r_phase   <= PH_LOAD;
            end
          end
        end
        ST_HIGH: begin
          if (r_phase != 16'd0) begin
            r_phase <= r_phase - 16'd1;
          end else begin
            r_pad_clk <= 1'b0;
            r_idx     <= r_idx + 3'd1;
            r_phase   <= PH_LOAD;
            r_state   <= ST_LOW;
          end
        end
        ST_DONE: begin
          r_buttons <= r_shift;
          r_valid   <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
`ifdef PAD_ATK_EDGE_EN
          r_btn_atk <= r_shift[BTN_A] & ~r_prev_a;
          r_prev_a  <= r_shift[BTN_A];
`else
          r_btn_atk <= r_shift[BTN_A];
`endif
        end
        default: begin
          r_state     <= ST_IDLE;
          r_pad_latch <= 1'b0;
          r_pad_clk   <= 1'b0;
          r_valid     <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pad_latch     = r_pad_latch;
  assign bus.pad_clk       = r_pad_clk;
  assign bus.buttons       = r_buttons;
  assign bus.btn_atk       = r_btn_atk;
  assign bus.btn_up        = r_buttons[BTN_UP];
  assign bus.btn_down      = r_buttons[BTN_DOWN];
  assign bus.btn_left      = r_buttons[BTN_LEFT];
  assign bus.btn_right     = r_buttons[BTN_RIGHT];
  assign bus.buttons_valid = r_valid;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_pad_reader.sv
// Bench for pad_reader at CLK_DIV = 4: cycle-level model plus directed scenarios.
module tb_pad_reader;

  localparam int C        = 4;
  localparam int DONE_CYC = 17 * C + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pad_reader_if bus ();

  pad_reader #(.CLK_DIV(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural pad: levels are electrical (0 = pressed), bit 0 presented after latch.
  logic [7:0] pad_levels = 8'hFF;
  logic [2:0] pidx       = 3'd0;
  logic       prev_pclk  = 1'b0;

  always @(posedge clk) begin
    prev_pclk <= bus.pad_clk;
    if (bus.pad_latch)
      pidx <= 3'd0;
    else if (bus.pad_clk && !prev_pclk)
      pidx <= pidx + 3'd1;
  end

  assign bus.pad_data = pad_levels[pidx];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state
  bit         m_active = 1'b0;
  int         m_c      = 0;
  logic [7:0] m_word   = 8'hFF;
  logic [7:0] m_buttons = 8'h00;
  logic       m_atk    = 1'b0;
  logic       m_prev_a = 1'b0;
  logic       tk, rs;

  // Observed activity counters, cleared by the stimulus at each tick
  int   obs_cyc = 0, obs_latch_hi = 0, obs_clk_hi = 0, obs_clk_rises = 0;
  int   obs_valid = 0, obs_valid_cyc = 0, obs_busy_fall = 0;
  logic obs_prev_clk = 1'b0, obs_prev_busy = 1'b0;

  initial begin : model_and_compare
    int  r;
    bit  e_latch, e_clk;
    forever begin
      @(posedge clk);
      tk = bus.frame_tick;
      rs = reset;
      #1;
      if (rs) begin
        m_active  = 1'b0;
        m_c       = 0;
        m_buttons = 8'h00;
        m_atk     = 1'b0;
        m_prev_a  = 1'b0;
      end else if (m_active) begin
        m_c++;
        if (m_c == DONE_CYC + 1) begin
          m_buttons = ~m_word;
`ifdef PAD_ATK_EDGE_EN
          m_atk    = m_buttons[0] & ~m_prev_a;
          m_prev_a = m_buttons[0];
`else
          m_atk = m_buttons[0];
`endif
          m_active = 1'b0;
        end
      end else if (tk) begin
        m_active = 1'b1;
        m_c      = 1;
        m_word   = pad_levels;
      end

      r       = m_c - (2 * C + 1);
      e_latch = m_active && (m_c <= 2 * C);
      e_clk   = m_active && (r >= 0) && (r < 15 * C) && (((r / C) % 2) == 1);

      check("pad_latch", 32'(bus.pad_latch), 32'(e_latch));
      check("pad_clk", 32'(bus.pad_clk), 32'(e_clk));
      check("buttons_valid", 32'(bus.buttons_valid), 32'(m_active && (m_c == DONE_CYC)));
      check("busy", 32'(bus.busy), 32'(m_active));
      check("buttons", 32'(bus.buttons), 32'(m_buttons));
      check("btn_up", 32'(bus.btn_up), 32'(m_buttons[4]));
      check("btn_down", 32'(bus.btn_down), 32'(m_buttons[5]));
      check("btn_left", 32'(bus.btn_left), 32'(m_buttons[6]));
      check("btn_right", 32'(bus.btn_right), 32'(m_buttons[7]));
      check("btn_atk", 32'(bus.btn_atk), 32'(m_atk));

      obs_cyc++;
      if (bus.pad_latch === 1'b1) obs_latch_hi++;
      if (bus.pad_clk === 1'b1) obs_clk_hi++;
      if (bus.pad_clk === 1'b1 && obs_prev_clk === 1'b0) obs_clk_rises++;
      if (bus.buttons_valid === 1'b1) begin
        obs_valid++;
        obs_valid_cyc = obs_cyc;
      end
      if (bus.busy === 1'b0 && obs_prev_busy === 1'b1 && obs_busy_fall == 0)
        obs_busy_fall = obs_cyc;
      obs_prev_clk  = bus.pad_clk;
      obs_prev_busy = bus.busy;
    end
  end

  task automatic clear_obs();
    obs_cyc = 0; obs_latch_hi = 0; obs_clk_hi = 0; obs_clk_rises = 0;
    obs_valid = 0; obs_valid_cyc = 0; obs_busy_fall = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    clear_obs();
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, " poll finished"}, 32'(k < 300), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " pad_latch"}, 32'(bus.pad_latch), 32'd0);
    check({name, " pad_clk"}, 32'(bus.pad_clk), 32'd0);
    check({name, " buttons"}, 32'(bus.buttons), 32'd0);
    check({name, " btn_atk"}, 32'(bus.btn_atk), 32'd0);
    check({name, " btn_up"}, 32'(bus.btn_up), 32'd0);
    check({name, " valid"}, 32'(bus.buttons_valid), 32'd0);
    check({name, " busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [7:0] seq [5] = '{8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFE};
`ifdef PAD_ATK_EDGE_EN
  logic [4:0] exp_atk = 5'b10001;
`else
  logic [4:0] exp_atk = 5'b10111;
`endif

  initial begin : stimulus
    bus.frame_tick = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Timing and decode: A, Up and Right pressed
    pad_levels = 8'b0110_1110;
    tick();
    wait_idle("decode");
    repeat (2) @(negedge clk);
    check("latch high cycles", 32'(obs_latch_hi), 32'd8);
    check("pad_clk rises", 32'(obs_clk_rises), 32'd7);
    check("pad_clk high cycles", 32'(obs_clk_hi), 32'd28);
    check("valid count", 32'(obs_valid), 32'd1);
    check("valid cycle", 32'(obs_valid_cyc), 32'd69);
    check("busy fall cycle", 32'(obs_busy_fall), 32'd70);
    check("decoded buttons", 32'(bus.buttons), 32'h91);
    check("decoded up", 32'(bus.btn_up), 32'd1);
    check("decoded right", 32'(bus.btn_right), 32'd1);
    check("decoded left", 32'(bus.btn_left), 32'd0);

    // Tick arriving mid-poll is dropped
    pad_levels = 8'hFE;
    tick();
    while (obs_cyc < 19) @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    wait_idle("busy tick");
    repeat (5) @(negedge clk);
    check("busy tick valid count", 32'(obs_valid), 32'd1);
    check("busy tick latch cycles", 32'(obs_latch_hi), 32'd8);
    check("no queued poll", 32'(bus.busy), 32'd0);
    check("busy tick buttons", 32'(bus.buttons), 32'h01);
    tick();
    check("next poll starts", 32'(bus.busy), 32'd1);
    wait_idle("after busy tick");
    check("second poll valid count", 32'(obs_valid), 32'd1);

    // Asynchronous reset in the middle of a poll with A held
    repeat (2) @(negedge clk);
    tick();
    while (obs_cyc < 30) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("mid-poll reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_obs();
    repeat (40) @(negedge clk);
    check("post-reset latch", 32'(obs_latch_hi), 32'd0);
    check("post-reset pad_clk", 32'(obs_clk_hi), 32'd0);
    check("post-reset valid", 32'(obs_valid), 32'd0);
    check("post-reset busy", 32'(bus.busy), 32'd0);

    // Attack over held, released and re-pressed A
    for (int i = 0; i < 5; i++) begin
      pad_levels = seq[i];
      tick();
      wait_idle("attack");
      @(negedge clk);
      check($sformatf("btn_atk poll %0d", i), 32'(bus.btn_atk), 32'(exp_atk[i]));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
